// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, return-address stack,
// stall hold and a two-state exception/ERET machine with EPC capture.
module pc_sequencer #(
  parameter int unsigned         XLEN         = 32,
  parameter int unsigned         OFFSET_W     = 16,
  parameter int unsigned         INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]     EXC_VECTOR   = XLEN'(32'h0000_0080),
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                in_stall,
  input  logic [2:0]          in_mode,
  input  logic                in_cond,
  input  logic [OFFSET_W-1:0] in_offset,
  input  logic [XLEN-1:0]     in_target,
  input  logic                in_link,
  input  logic                in_exc,
  input  logic                in_eret,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_pc_plus,
  output logic [XLEN-1:0]     out_epc,
  output logic                out_in_exc,
  output logic                out_ras_empty,
  output logic                out_ras_full,
  output logic                out_ras_ovf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SEXT_W = XLEN - OFFSET_W;

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  localparam logic [2:0] MODE_SEQ    = 3'd0;
  localparam logic [2:0] MODE_BRANCH = 3'd1;
  localparam logic [2:0] MODE_JUMP   = 3'd2;
  localparam logic [2:0] MODE_JREG   = 3'd3;
  localparam logic [2:0] MODE_RET    = 3'd4;

  logic [0:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top_q, ras_top_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic             ras_ovf_q, ras_ovf_d;

  logic [XLEN-1:0]  pc_plus;
  logic [XLEN-1:0]  offset_sext;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  ras_top_val;
  logic [PTR_W-1:0] ras_push_ptr;
  logic             ras_empty;
  logic             ras_full;
  logic             push;
  logic             pop;

  // Candidate next-PC values
  always_comb begin
    pc_plus       = pc_q + XLEN'(INSTR_BYTES);
    offset_sext   = {{SEXT_W{in_offset[OFFSET_W-1]}}, in_offset};
    branch_target = pc_plus + (offset_sext << 2);
    jump_target   = {pc_plus[XLEN-1:XLEN-4], in_target[XLEN-7:0], 2'b00};
    ras_top_val   = ras_mem_q[ras_top_q];
    ras_push_ptr  = PTR_W'(ras_top_q + 1'b1);
    ras_empty     = (ras_cnt_q == '0);
    ras_full      = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  end

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_NORMAL;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state / next-PC: exception > eret > stall > mode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (in_exc) begin
      // A nested exception re-vectors but keeps the original EPC
      if (state_q == ST_NORMAL) begin
        epc_d = pc_q;
      end
      pc_d    = EXC_VECTOR;
      state_d = ST_HANDLER;
    end else if (in_eret && (state_q == ST_HANDLER)) begin
      pc_d    = epc_q;
      state_d = ST_NORMAL;
    end else if (!in_stall) begin
      case (in_mode)
        MODE_BRANCH: pc_d = in_cond ? branch_target : pc_plus;
        MODE_JUMP: begin
          pc_d = jump_target;
          push = in_link;
        end
        MODE_JREG: begin
          pc_d = in_target;
          push = in_link;
        end
        MODE_RET: begin
          if (!ras_empty) begin
            pc_d = ras_top_val;
            pop  = 1'b1;
          end else begin
            pc_d = in_target;
          end
        end
        default: pc_d = pc_plus;
      endcase
    end
  end

  // Return-address stack bookkeeping; a full push overwrites the oldest slot
  always_comb begin
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    ras_ovf_d = ras_ovf_q;
    if (push) begin
      ras_top_d = ras_push_ptr;
      if (ras_full) begin
        ras_ovf_d = 1'b1;
      end else begin
        ras_cnt_d = CNT_W'(ras_cnt_q + 1'b1);
      end
    end else if (pop) begin
      ras_top_d = PTR_W'(ras_top_q - 1'b1);
      ras_cnt_d = CNT_W'(ras_cnt_q - 1'b1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      ras_top_q <= '0;
      ras_cnt_q <= '0;
      ras_ovf_q <= 1'b0;
    end else begin
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
      ras_ovf_q <= ras_ovf_d;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
    end else if (push) begin
      ras_mem_q[ras_push_ptr] <= pc_plus;
    end
  end

  assign out_pc        = pc_q;
  assign out_pc_plus   = pc_plus;
  assign out_epc       = epc_q;
  assign out_in_exc    = (state_q == ST_HANDLER);
  assign out_ras_empty = ras_empty;
  assign out_ras_full  = ras_full;
  assign out_ras_ovf   = ras_ovf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PCs are queued as each step is
// driven and popped for comparison after the clock edge that applies it.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  mode;
  logic        cond;
  logic [15:0] offset;
  logic [31:0] target;
  logic        link;
  logic        exc;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic        in_exc_o;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  pc_sequencer dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_stall      (stall),
    .in_mode       (mode),
    .in_cond       (cond),
    .in_offset     (offset),
    .in_target     (target),
    .in_link       (link),
    .in_exc        (exc),
    .in_eret       (eret),
    .out_pc        (pc),
    .out_pc_plus   (pc_plus),
    .out_epc       (epc),
    .out_in_exc    (in_exc_o),
    .out_ras_empty (ras_empty),
    .out_ras_full  (ras_full),
    .out_ras_ovf   (ras_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic c, input logic [15:0] off,
                       input logic [31:0] tgt, input logic lk, input logic st,
                       input logic ex, input logic er);
    mode = m; cond = c; offset = off; target = tgt;
    link = lk; stall = st; exc = ex; eret = er;
  endtask

  // Queue the expectation, clock once, then pop and compare
  task automatic tick(input string tag, input logic [31:0] exp_pc);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp_pc);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, pc, e);
    chk({t, "_plus"}, pc_plus, e + 32'd4);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_ovf", 32'(ras_ovf), 32'd0);
    chk("rst_inexc", 32'(in_exc_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential stepping
    tick("seq1", 32'h4);
    tick("seq2", 32'h8);
    tick("seq3", 32'hC);

    // Branches
    drive(3'd3, 1'b0, 16'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0); tick("jreg100", 32'h100);
    drive(3'd1, 1'b1, 16'hFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("br_neg", 32'hFC);
    drive(3'd3, 1'b0, 16'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0); tick("jreg100b", 32'h100);
    drive(3'd1, 1'b0, 16'hFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("br_nt", 32'h104);
    drive(3'd1, 1'b1, 16'h0003, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("br_pos", 32'h114);

    // Wrap and reserved mode
    drive(3'd3, 1'b0, 16'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0); tick("jreg_top", 32'hFFFF_FFFC);
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("seq_wrap", 32'h0);
    drive(3'd7, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("mode7", 32'h4);

    // Jump keeps upper nibble of pc+4
    drive(3'd3, 1'b0, 16'h0, 32'hF000_0000, 1'b0, 1'b0, 1'b0, 1'b0); tick("jreg_f", 32'hF000_0000);
    drive(3'd2, 1'b0, 16'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0); tick("jump_hi", 32'hFFFF_FFFC);

    // Call / return
    drive(3'd3, 1'b0, 16'h0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0); tick("jreg1000", 32'h1000);
    drive(3'd2, 1'b0, 16'h0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0); tick("jal", 32'h100);
    chk("jal_empty", 32'(ras_empty), 32'd0);
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("seq104", 32'h104);
    drive(3'd4, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("ret", 32'h1004);
    chk("ret_empty", 32'(ras_empty), 32'd1);
    drive(3'd4, 1'b0, 16'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0); tick("ret_fallback", 32'h200);

    // Five linked calls into a four-deep stack
    drive(3'd3, 1'b0, 16'h0, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0); tick("call_a", 32'h2000);
    drive(3'd3, 1'b0, 16'h0, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0); tick("call_b", 32'h3000);
    drive(3'd3, 1'b0, 16'h0, 32'h4000, 1'b1, 1'b0, 1'b0, 1'b0); tick("call_c", 32'h4000);
    drive(3'd3, 1'b0, 16'h0, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b0); tick("call_d", 32'h5000);
    chk("full4", 32'(ras_full), 32'd1);
    chk("ovf4", 32'(ras_ovf), 32'd0);
    drive(3'd3, 1'b0, 16'h0, 32'h6000, 1'b1, 1'b0, 1'b0, 1'b0); tick("call_e", 32'h6000);
    chk("full5", 32'(ras_full), 32'd1);
    chk("ovf5", 32'(ras_ovf), 32'd1);
    drive(3'd4, 1'b0, 16'h0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0); tick("ret_e", 32'h5004);
    chk("pop_notfull", 32'(ras_full), 32'd0);
    tick("ret_d", 32'h4004);
    tick("ret_c", 32'h3004);
    tick("ret_b", 32'h2004);
    chk("drain_empty", 32'(ras_empty), 32'd1);
    chk("ovf_sticky", 32'(ras_ovf), 32'd1);
    drive(3'd4, 1'b0, 16'h0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0); tick("ret_fb300", 32'h300);

    // Exception over stall, nested exception, eret
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); tick("exc", 32'h80);
    chk("exc_epc", epc, 32'h300);
    chk("exc_flag", 32'(in_exc_o), 32'd1);
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("h_seq", 32'h84);
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick("exc_nest", 32'h80);
    chk("nest_epc", epc, 32'h300);
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick("eret", 32'h300);
    chk("eret_flag", 32'(in_exc_o), 32'd0);
    tick("eret_normal", 32'h304);
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1); tick("eret_stall", 32'h304);

    // Stall holds PC and RAS
    drive(3'd3, 1'b0, 16'h0, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0); tick("call500", 32'h500);
    drive(3'd3, 1'b0, 16'h0, 32'h999, 1'b1, 1'b1, 1'b0, 1'b0); tick("stall1", 32'h500);
    tick("stall2", 32'h500);
    drive(3'd4, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("ret_after_stall", 32'h308);
    chk("stall_empty", 32'(ras_empty), 32'd1);

    // Async reset mid-stall
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick("stall3", 32'h308);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ovf", 32'(ras_ovf), 32'd0);
    chk("arst_epc", epc, 32'h0);
    #1 rst_n = 1'b1;
    drive(3'd0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick("post_rst", 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; the next generation of the datapath's PC-calculation block.
- Holds the architectural PC in a register and selects the next PC from sequential, branch, jump, jump-register or return modes.
- Adds a return-address stack, stall hold, and an exception/ERET state machine with EPC capture.
- Sits between control/decoder outputs and the instruction-memory address input.

Parameters:
XLEN, 32, PC and target width in bits
OFFSET_W, 16, branch offset width (word offset, signed)
INSTR_BYTES, 4, sequential increment in bytes
RESET_VECTOR, 32'h0000_0000, PC value after reset
EXC_VECTOR, 32'h0000_0080, exception handler entry address
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_stall  input  1  hold PC and RAS this cycle
in_mode  input  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 RET, 5-7 treated as SEQ
in_cond  input  1  branch taken when mode=BRANCH
in_offset  input  OFFSET_W  signed word offset for BRANCH
in_target  input  XLEN  jump index (JUMP), register target (JREG), fallback (RET on empty)
in_link  input  1  with JUMP/JREG: push return address onto RAS
in_exc  input  1  exception request
in_eret  input  1  return from exception
out_pc  output  XLEN  current PC (registered)
out_pc_plus  output  XLEN  out_pc + INSTR_BYTES (combinational)
out_epc  output  XLEN  saved exception PC
out_in_exc  output  1  1 while in HANDLER state
out_ras_empty  output  1  RAS holds no entries
out_ras_full  output  1  RAS holds RAS_DEPTH entries
out_ras_ovf  output  1  sticky: a push overwrote an entry

Behaviour:
- Reset (async, in_rst_n=0): out_pc=RESET_VECTOR, out_epc=0, state NORMAL, RAS count=0, out_ras_ovf=0.
- All updates on rising in_clk; new PC visible one cycle after the request (latency 1).
- Arithmetic modulo 2^XLEN, wrap silently.
- Next-PC priority per cycle: in_exc > in_eret > in_stall > in_mode.
- SEQ: pc+INSTR_BYTES.
- BRANCH: in_cond=1 -> pc+INSTR_BYTES+(sext(in_offset)<<2); in_cond=0 -> pc+INSTR_BYTES.
- JUMP: {pc_plus[XLEN-1:XLEN-4], in_target[XLEN-5:0]<<2} truncated to XLEN.
- JREG: in_target.
- RET: RAS non-empty -> top entry, pop; empty -> in_target, no pop.
- in_link with JUMP/JREG: push out_pc_plus. Ignored for other modes.
- Push when full: overwrite oldest entry (circular), count stays RAS_DEPTH, set out_ras_ovf until reset.
- Push and pop never coincide (link only valid with JUMP/JREG).
- Stall: PC, RAS, EPC and state unchanged; in_mode/in_link ignored.
- State machine:
  - NORMAL: in_exc -> out_epc<=out_pc, PC<=EXC_VECTOR, go HANDLER. in_eret ignored (treated as SEQ/normal mode).
  - HANDLER: in_exc -> PC<=EXC_VECTOR, out_epc NOT overwritten (nested exception re-vectors). in_eret (no in_exc) -> PC<=out_epc, go NORMAL. Otherwise normal mode processing.
- Exceptions and ERET override stall and never modify the RAS.
- Reset mid-operation: all state returns to reset values immediately, independent of clock.

Test Plan:
- Reset release, mode=SEQ 3 cycles -> out_pc 0x0, 0x4, 0x8, 0xC; out_pc_plus tracks +4.
- pc=0x100, BRANCH cond=1 offset=16'hFFFE -> 0xFC; cond=0 -> 0x104; pc=0xFFFF_FFFC SEQ -> 0x0 (wrap).
- pc=0x1000 JUMP link target=0x40 -> pc=0x100, RAS top=0x1004; later RET -> 0x1004, out_ras_empty=1; RET on empty with target=0x200 -> 0x200.
- RAS_DEPTH=4: five linked JREGs from pcs A..E -> out_ras_full=1, out_ras_ovf=1; four RETs return E+4, D+4, C+4, B+4.
- pc=0x300 in_exc with in_stall=1 -> pc=0x80, out_epc=0x300, out_in_exc=1; nested in_exc at 0x84 -> pc=0x80, epc still 0x300; in_eret -> pc=0x300, out_in_exc=0.
- in_stall=1 for 2 cycles with mode=JREG link -> pc and RAS unchanged; async reset pulse mid-stall -> pc=RESET_VECTOR before next edge.
